// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver, LSB first. Synchronises the asynchronous rx
//             pin, detects the start bit, samples every bit at its centre and
//             presents each received byte with a one-cycle valid pulse.
//  Ports    : clk        - system clock
//             rst_n      - asynchronous active-low reset
//             rx         - serial input, idle high, asynchronous to clk
//             busy       - high while a frame is in progress (not IDLE)
//             valid      - one-cycle pulse, dout holds a good byte
//             frame_err  - one-cycle pulse, stop bit was sampled low
//             dout       - last received byte, held until the next frame ends
//  Options  : UART_RX_MAJORITY_EN - when defined, every sample point uses the
//             2-of-3 majority of the last three synchronised rx values.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       busy,
    output logic       valid,
    output logic       frame_err,
    output logic [7:0] dout
);

    localparam logic [15:0] c_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_HIGH = 3'd4;

    logic        r_sync1;
    logic        r_rx_s;
    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [15:0] r_count;
    logic [2:0]  r_index;
    logic [7:0]  r_shift;
    logic [7:0]  r_dout;
    logic        r_valid;
    logic        r_frame_err;
    logic        w_bit;
    logic        w_sample;
    logic        w_valid_next;
    logic        w_err_next;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Two previous rx_s values plus the current one form the 3-sample window,
    // so the vote adds no delay to the sample points.
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    // Next-state and pulse decode.
    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = c_START;
                end
            end
            c_START: begin
                if (r_count == c_HALF_LAST) begin
                    w_sample     = 1'b1;
                    // A high sample here is a glitch or false start.
                    w_state_next = w_bit ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (r_count == c_BIT_LAST) begin
                    w_sample = 1'b1;
                    if (r_index == 3'd7) begin
                        w_state_next = c_STOP;
                    end
                end
            end
            c_STOP: begin
                if (r_count == c_BIT_LAST) begin
                    w_sample = 1'b1;
                    if (w_bit) begin
                        w_valid_next = 1'b1;
                        w_state_next = c_IDLE;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = c_WAIT_HIGH;
                    end
                end
            end
            c_WAIT_HIGH: begin
                // Hold here through a break so it reports only one error.
                if (r_rx_s) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_count     <= 16'd0;
            r_index     <= 3'd0;
            r_shift     <= 8'd0;
            r_dout      <= 8'd0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_err_next;

            // Restart the bit timer on every state change and after every
            // sample, so each DATA bit is timed from the previous centre.
            if (w_sample || (w_state_next != r_state) ||
                (r_state == c_IDLE) || (r_state == c_WAIT_HIGH)) begin
                r_count <= 16'd0;
            end else begin
                r_count <= r_count + 16'd1;
            end

            // index wraps 7 -> 0 on the last data bit, ready for the next frame.
            if ((r_state == c_DATA) && w_sample) begin
                r_shift[r_index] <= w_bit;
                r_index          <= r_index + 3'd1;
            end

            // The byte is published on a framing error as well.
            if ((r_state == c_STOP) && w_sample) begin
                r_dout <= r_shift;
            end
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign dout      = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx at CLKS_PER_BIT=16. A table of
//             frames feeds a scoreboard queue; a monitor pops an expected
//             entry for each valid/frame_err pulse. Hand sequences cover the
//             false start, reset mid-frame and latency corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] c_GLITCH_EXP = 8'hFF;
`else
    localparam logic [7:0] c_GLITCH_EXP = 8'hF7;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       busy;
    logic       valid;
    logic       frame_err;
    logic [7:0] dout;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .busy     (busy),
        .valid    (valid),
        .frame_err(frame_err),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] dout;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        int         gap;
        int         low_after;
        logic [7:0] exp_dout;
        logic       exp_err;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_pulse_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (valid || frame_err)) begin
            last_pulse_cyc = cyc;
            check("pulse_exclusive", 32'(valid & frame_err), 32'd0);
            check("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("dout", 32'(dout), 32'(e.dout));
                check("frame_err", 32'(frame_err), 32'(e.err));
                check("busy_at_pulse", 32'(busy), 32'(e.err));
            end
        end
    end

    // One rx value per clock; k-th value lands at bit k/CPB, cycle k%CPB.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input logic glitch, input int ncyc);
        logic [9:0] fw;
        fw = {stop, data, 1'b0};
        for (int k = 0; k < ncyc; k++) begin
            int b;
            int c;
            b  = k / CPB;
            c  = k % CPB;
            rx = (glitch && b == 4 && c == HALF) ? 1'b0 : fw[b];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input int n, input logic lvl);
        rx = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < CPB * 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];
    int   nbusy;
    int   t0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 5,   0,   8'hA5,        1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 5,   0,   8'h00,        1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 0,   0,   8'hFF,        1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 5,   100, 8'h3C,        1'b1};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 10,  0,   8'h81,        1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 5,   0,   c_GLITCH_EXP, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 1'b0, 5,   0,   8'h01,        1'b0};
        vecs[7] = '{8'h80, 1'b1, 1'b0, 0,   0,   8'h80,        1'b0};

        // Reset state
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven frames, including back-to-back and break cases.
        for (int i = 0; i < 8; i++) begin
            hold(vecs[i].gap, 1'b1);
            sb.push_back('{vecs[i].exp_dout, vecs[i].exp_err});
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].glitch, 10 * CPB);
            if (vecs[i].low_after > 0) hold(vecs[i].low_after, 1'b0);
        end
        hold(2, 1'b1);
        drain("table_drain");

        // False start: 4-cycle low pulse on an idle line.
        hold(5, 1'b1);
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            rx = (k < 4) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (busy) nbusy++;
        end
        check("false_start_busy_cycles", 32'(nbusy), 32'(HALF));
        check("false_start_idle", 32'(busy), 32'd0);

        // Latency from the rx falling edge to valid.
        hold(5, 1'b1);
        t0 = cyc;
        sb.push_back('{8'hC3, 1'b0});
        send_frame(8'hC3, 1'b1, 1'b0, 10 * CPB);
        drain("latency_drain");
        check("latency_cycles", 32'(last_pulse_cyc - t0), 32'(3 + HALF + 9 * CPB));

        // Reset during data bit 4 of 0x77: frame abandoned silently.
        hold(5, 1'b1);
        send_frame(8'h77, 1'b1, 1'b0, 5 * CPB + HALF);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(valid), 32'd0);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        check("midreset_dout", 32'(dout), 32'd0);
        rx = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(CPB * 12, 1'b1);
        check("midreset_no_pulse", 32'(sb.size()), 32'd0);
        sb.push_back('{8'h5A, 1'b0});
        send_frame(8'h5A, 1'b1, 1'b0, 10 * CPB);
        hold(2, 1'b1);
        drain("after_reset_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
